pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RegAddrLen, default 5, meaning register-file address width.
REQ-002 SHALL have parameter StallCntLen, default 32, meaning stall performance counter width.
REQ-003 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have if_inst_ok input 1, meaning the fetch stage presents a valid instruction this cycle.
REQ-005 SHALL have id_rs1/id_rs2 input RegAddrLen, meaning ID source registers, and id_rs1_use/id_rs2_use input 1, meaning each source is read.
REQ-006 SHALL have ex_is_load input 1, meaning EX holds a load; ex_rd input RegAddrLen, meaning EX destination register.
REQ-007 SHALL have ex_busy input 1, meaning a multi-cycle EX op is unfinished; ex_br_taken input 1, meaning EX resolved a taken branch.
REQ-008 SHALL have outputs if_id_en, id_ex_en, ex_mem_en, mem_wb_en (output 1 each), meaning pipeline-register load enables.
REQ-009 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush (output 1 each), meaning load a zero bubble instead of upstream data.
REQ-010 SHALL have outputs id_valid, ex_valid, mem_valid, wb_valid (output 1 each), meaning the stage holds a real instruction.
REQ-011 SHALL have redirect output 1, meaning fetch must take the branch target; stall_cnt output StallCntLen, meaning stall cycles counted.

Function
REQ-012 SHALL track stage valids in registers: on a stage's register enable, the stage valid takes upstream valid AND NOT its flush; it holds otherwise.
REQ-013 SHALL derive hazards combinationally: ldu = ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_use & id_rs1==ex_rd) | (id_rs2_use & id_rs2==ex_rd)) & id_valid; br = ex_valid & ex_br_taken.
REQ-014 SHALL implement FSM states RUN, EXWAIT, REDIRECT; RUN->EXWAIT when ex_valid & ex_busy; EXWAIT->RUN when ex_busy falls; RUN->REDIRECT when br & !ex_busy; REDIRECT->RUN unconditionally after one cycle.
REQ-015 SHALL apply priority busy > branch > load-use > fetch-empty, evaluated each cycle.
REQ-016 SHALL during ex_valid & ex_busy: if_id_en=id_ex_en=0, ex_mem_en=1 with ex_mem_flush=1, mem_wb_en=1 (younger held, bubble drains downstream).
REQ-017 SHALL on br (not busy): all enables 1, if_id_flush=id_ex_flush=1, EX instruction advances into MEM.
REQ-018 SHALL assert redirect for exactly the one cycle in state REDIRECT and force if_id_flush=1 in that cycle.
REQ-019 SHALL on ldu (no busy, no br): if_id_en=0 (ID held), id_ex_en=1 with id_ex_flush=1; the stall releases the cycle after the load leaves EX.
REQ-020 SHALL when if_inst_ok=0 with no higher-priority event: if_id_en=1, if_id_flush=1.
REQ-021 SHALL otherwise assert all enables with all flushes 0.
REQ-022 SHALL increment stall_cnt by 1 on each cycle with busy-stall or ldu-stall, saturating at all-ones (no wrap).
REQ-023 SHALL treat ex_rd==0 as no hazard, and ignore ex_busy and ex_br_taken when ex_valid=0.

Reset
REQ-024 SHALL on rst_n=0 asynchronously clear all stage valids, stall_cnt to 0, FSM to RUN, redirect to 0.
REQ-025 SHALL, while rst_n=0, drive all enables 1 and all flushes 1 so pipeline registers load bubbles.
REQ-026 SHALL abandon any stall or redirect in progress on reset mid-operation, with no pulse after release.

Verification
REQ-027 SHALL verify load-use: EX load ex_rd=5, ID id_rs1=5 use=1 -> one cycle if_id_en=0, id_ex_flush=1, ex_valid=0 next cycle, stall_cnt +1.
REQ-028 SHALL verify ex_busy held 4 cycles -> if_id_en=id_ex_en=0 for 4 cycles, mem_valid=0 bubbles, FSM EXWAIT then RUN, stall_cnt +4.
REQ-029 SHALL verify branch taken with ID and IF valid -> next cycle id_valid=0, ex_valid=0, mem_valid=1, redirect=1 for exactly one cycle.
REQ-030 SHALL verify simultaneous br and ldu -> branch flush only, stall_cnt unchanged; simultaneous busy and br -> redirect only after ex_busy falls.
REQ-031 SHALL verify ex_rd=0 load with matching id_rs1=0 -> no stall; stall_cnt preloaded to all-ones -> stays all-ones on stall.
REQ-032 SHALL verify rst_n low during EXWAIT -> all valids 0 immediately, FSM RUN, no redirect after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stage valids, stall/flush/redirect
// control by busy > branch > load-use > fetch-empty priority, and a stall counter.
module pipe_ctrl #(
  parameter int unsigned RegAddrLen  = 5,
  parameter int unsigned StallCntLen = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_inst_ok,
  input  logic [RegAddrLen-1:0]  id_rs1,
  input  logic [RegAddrLen-1:0]  id_rs2,
  input  logic                   id_rs1_use,
  input  logic                   id_rs2_use,
  input  logic                   ex_is_load,
  input  logic [RegAddrLen-1:0]  ex_rd,
  input  logic                   ex_busy,
  input  logic                   ex_br_taken,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   id_valid,
  output logic                   ex_valid,
  output logic                   mem_valid,
  output logic                   wb_valid,
  output logic                   redirect,
  output logic [StallCntLen-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StExWait, StRedirect} state_e;

  state_e                 r_state, w_state_d;
  logic                   r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;
  logic [StallCntLen-1:0] r_stall_cnt;
  logic                   w_busy, w_br, w_ldu, w_stall;
  logic                   w_rs1_hit, w_rs2_hit;

  assign w_busy    = r_ex_valid & ex_busy;
  assign w_br      = r_ex_valid & ex_br_taken;
  assign w_rs1_hit = id_rs1_use & (id_rs1 == ex_rd);
  assign w_rs2_hit = id_rs2_use & (id_rs2 == ex_rd);
  assign w_ldu     = r_ex_valid & ex_is_load & (ex_rd != '0) & (w_rs1_hit | w_rs2_hit) & r_id_valid;
  assign w_stall   = w_busy | (w_ldu & ~w_br);

  assign id_valid  = r_id_valid;
  assign ex_valid  = r_ex_valid;
  assign mem_valid = r_mem_valid;
  assign wb_valid  = r_wb_valid;
  assign redirect  = (r_state == StRedirect);
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_busy) begin
      // Hold IF/ID and ID/EX; a bubble drains into MEM behind the busy op.
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (w_br) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_ldu) begin
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!if_inst_ok) begin
      if_id_flush = 1'b1;
    end
    if (r_state == StRedirect) if_id_flush = 1'b1;
  end

  // A branch resolving as the busy op finishes still needs its redirect cycle.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRun: begin
        if (w_busy)    w_state_d = StExWait;
        else if (w_br) w_state_d = StRedirect;
      end
      StExWait: begin
        if (!w_busy) w_state_d = w_br ? StRedirect : StRun;
      end
      StRedirect: w_state_d = StRun;
      default:    w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_id_valid  <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (if_id_en)  r_id_valid  <= if_inst_ok & ~if_id_flush;
      if (id_ex_en)  r_ex_valid  <= r_id_valid & ~id_ex_flush;
      if (ex_mem_en) r_mem_valid <= r_ex_valid & ~ex_mem_flush;
      if (mem_wb_en) r_wb_valid  <= r_mem_valid;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + StallCntLen'(1);
    end
  end

endmodule
